// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared types and width helpers for the DA tap window
package da_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SLICE = 2'd2
  } da_state_t;

  localparam int DA_SLIDING = 0;
  localparam int DA_BLOCK   = 1;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/da_tap_shift.sv
// rtl/da_tap_shift.sv - N-deep W-bit tap delay line with shift enable and clear
module da_tap_shift
  import da_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [W-1:0]   din,
  output logic [N*W-1:0] taps
);

  // Tap 0 holds the newest sample; older samples move toward tap N-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      taps <= '0;
    end else if (en) begin
      for (int k = N - 1; k > 0; k--) begin
        taps[k*W +: W] <= taps[(k-1)*W +: W];
      end
      taps[W-1:0] <= din;
    end
  end

endmodule

// File: rtl/da_tap_window.sv
// rtl/da_tap_window.sv - sample window that emits bit-slice table addresses to a DA accumulator
module da_tap_window
  import da_pkg::*;
#(
  parameter int W    = 8,
  parameter int N    = 16,
  parameter int MODE = DA_SLIDING
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic [N*W-1:0]           taps,
  output logic [fill_width(N)-1:0] fill_count,
  output logic                     slice_valid,
  input  logic                     slice_ready,
  output logic [N-1:0]             slice_bits,
  output logic [idx_width(W)-1:0]  slice_idx,
  output logic                     slice_msb,
  output logic                     slice_last
);

  localparam int FW = fill_width(N);
  localparam int IW = idx_width(W);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);

  da_state_t      state, state_nx;
  logic [FW-1:0]  fill_nx;
  logic [IW-1:0]  idx_nx;
  logic           accept;
  logic           shift_en;
  logic           slice_hs;

  assign accept   = in_valid & in_ready;
  assign shift_en = accept & ~clr;
  assign slice_hs = slice_valid & slice_ready;

  da_tap_shift #(
    .W (W),
    .N (N)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (shift_en),
    .din  (in_data),
    .taps (taps)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      fill_count <= '0;
      slice_idx  <= '0;
    end else begin
      state      <= state_nx;
      fill_count <= fill_nx;
      slice_idx  <= idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fill_nx     = fill_count;
    idx_nx      = slice_idx;
    in_ready    = 1'b0;
    slice_valid = 1'b0;
    case (state)
      FILL, READY: begin
        in_ready = ~rst;
        if (shift_en) begin
          if (fill_count != FILL_FULL) fill_nx = fill_count + 1'b1;
          // In READY the window is already full, so every accept starts a burst.
          if (fill_count >= FILL_FULL - 1'b1) state_nx = SLICE;
        end
      end
      SLICE: begin
        slice_valid = 1'b1;
        if (slice_hs) begin
          if (slice_idx == IDX_LAST) begin
            idx_nx = '0;
            if (MODE == DA_BLOCK) begin
              state_nx = FILL;
              fill_nx  = '0;
            end else begin
              state_nx = READY;
            end
          end else begin
            idx_nx = slice_idx + 1'b1;
          end
        end
      end
      default: state_nx = FILL;
    endcase
    if (clr) begin
      state_nx = FILL;
      fill_nx  = '0;
      idx_nx   = '0;
    end
  end

  always_comb begin
    slice_bits = '0;
    if (slice_valid) begin
      for (int k = 0; k < N; k++) begin
        slice_bits[k] = taps[k*W + int'(slice_idx)];
      end
    end
  end

  assign slice_msb  = (slice_idx == IDX_LAST);
  assign slice_last = slice_msb;

endmodule

// File: tb/tb_da_tap_window.sv
// tb/tb_da_tap_window.sv - self-checking bench for da_tap_window in sliding and block modes
module tb_da_tap_window;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int FW = $clog2(N + 1);
  localparam int IW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]         clr_i;
  logic [1:0]         valid_i;
  logic [1:0]         sready_i;
  logic [1:0][W-1:0]  data_i;

  logic [1:0]           ready_o;
  logic [1:0]           sv_o;
  logic [1:0]           msb_o;
  logic [1:0]           last_o;
  logic [1:0][N*W-1:0]  taps_o;
  logic [1:0][FW-1:0]   fill_o;
  logic [1:0][N-1:0]    bits_o;
  logic [1:0][IW-1:0]   idx_o;

  always #5 clk = ~clk;

  da_tap_window #(.W(W), .N(N), .MODE(0)) u_slide (
    .clk(clk), .rst(rst), .clr(clr_i[0]),
    .in_valid(valid_i[0]), .in_ready(ready_o[0]), .in_data(data_i[0]),
    .taps(taps_o[0]), .fill_count(fill_o[0]),
    .slice_valid(sv_o[0]), .slice_ready(sready_i[0]), .slice_bits(bits_o[0]),
    .slice_idx(idx_o[0]), .slice_msb(msb_o[0]), .slice_last(last_o[0])
  );

  da_tap_window #(.W(W), .N(N), .MODE(1)) u_block (
    .clk(clk), .rst(rst), .clr(clr_i[1]),
    .in_valid(valid_i[1]), .in_ready(ready_o[1]), .in_data(data_i[1]),
    .taps(taps_o[1]), .fill_count(fill_o[1]),
    .slice_valid(sv_o[1]), .slice_ready(sready_i[1]), .slice_bits(bits_o[1]),
    .slice_idx(idx_o[1]), .slice_msb(msb_o[1]), .slice_last(last_o[1])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window model: a sample list, a fill count and a burst position (-1 = idle).
  logic [W-1:0] m_win [2][N];
  int           m_fill [2];
  int           m_pos  [2];
  bit           m_init = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || clr_i[i]) begin
        for (int k = 0; k < N; k++) m_win[i][k] = '0;
        m_fill[i] = 0;
        m_pos[i]  = -1;
      end else if (m_pos[i] >= 0) begin
        if (sready_i[i]) begin
          if (m_pos[i] == W - 1) begin
            m_pos[i] = -1;
            if (i == 1) m_fill[i] = 0;
          end else begin
            m_pos[i]++;
          end
        end
      end else if (valid_i[i]) begin
        for (int k = N - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
        m_win[i][0] = data_i[i];
        if (m_fill[i] < N) m_fill[i]++;
        if (m_fill[i] == N) m_pos[i] = 0;
      end
    end
    if (rst) m_init = 1'b1;
  end

  logic [N*W-1:0] et;
  logic [N-1:0]   eb;
  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        et = '0;
        eb = '0;
        for (int k = 0; k < N; k++) begin
          et[k*W +: W] = m_win[i][k];
          if (m_pos[i] >= 0) eb[k] = m_win[i][k][m_pos[i]];
        end
        chk($sformatf("in_ready%0d", i), ready_o[i], !rst && m_pos[i] < 0);
        chk($sformatf("slice_valid%0d", i), sv_o[i], m_pos[i] >= 0);
        chk($sformatf("slice_idx%0d", i), idx_o[i], (m_pos[i] >= 0) ? m_pos[i] : 0);
        chk($sformatf("slice_bits%0d", i), bits_o[i], eb);
        chk($sformatf("slice_msb%0d", i), msb_o[i], m_pos[i] == W - 1);
        chk($sformatf("slice_last%0d", i), last_o[i], m_pos[i] == W - 1);
        chk($sformatf("taps%0d", i), taps_o[i], et);
        chk($sformatf("fill_count%0d", i), fill_o[i], m_fill[i]);
      end
    end
  end

  int  bursts1 = 0;
  logic sv1_prev = 1'b0;
  always @(negedge clk) begin
    if (sv_o[1] && !sv1_prev) bursts1++;
    sv1_prev = sv_o[1];
  end

  task automatic send(input int i, input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    valid_i[i] = 1'b1;
    data_i[i]  = d;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (ready_o[i]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    valid_i[i] = 1'b0;
    chk($sformatf("send%0d_accepted", i), done, 1'b1);
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sv_o[i]) break;
    end
    chk($sformatf("burst_end%0d", i), sv_o[i], 1'b0);
  endtask

  int hs, stalls;
  logic [N-1:0]   cap_bits;
  logic [N*W-1:0] cap_taps;

  initial begin
    clr_i = '0; valid_i = '0; sready_i = '1; data_i = '0;

    // Reset release with a sample offered throughout.
    valid_i[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_taps", taps_o[0], '0);
      chk("rst_fill", fill_o[0], '0);
      chk("rst_valid", sv_o[0], 1'b0);
      chk("rst_ready", ready_o[0], 1'b0);
    end
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", ready_o[0], 1'b1);
    valid_i[0] = 1'b0;

    // Sliding window: 1,2,3,4 then 5.
    for (int s = 1; s <= 4; s++) send(0, W'(s));
    @(negedge clk);
    chk("first_slice_valid", sv_o[0], 1'b1);
    chk("first_slice_idx", idx_o[0], 0);
    chk("first_slice_bits", bits_o[0], 4'b1010);
    for (int j = 1; j < W; j++) begin
      @(negedge clk);
      chk("walk_idx", idx_o[0], j);
      chk("walk_last", last_o[0], j == 7);
    end
    @(negedge clk);
    chk("post_burst_valid", sv_o[0], 1'b0);
    chk("post_burst_ready", ready_o[0], 1'b1);
    send(0, 8'd5);
    @(negedge clk);
    chk("sample5_bits", bits_o[0], 4'b0101);
    wait_done(0);

    // Sign: four samples of -1.
    for (int s = 0; s < 4; s++) send(0, 8'hFF);
    for (int j = 0; j < W; j++) begin
      @(negedge clk);
      chk("neg_bits", bits_o[0], 4'b1111);
      chk("neg_msb", msb_o[0], j == 7);
    end
    wait_done(0);

    // Back-pressure at idx 2 with a sample offered during the stall.
    send(0, 8'h12);
    hs = 0;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sv_o[0]) break;
      if (idx_o[0] == 2) begin
        if (stalls == 0) begin
          cap_bits = bits_o[0];
          cap_taps = taps_o[0];
          chk("stall_bits_literal", cap_bits, 4'b1110);
        end else begin
          chk("stall_bits_held", bits_o[0], cap_bits);
          chk("stall_taps_held", taps_o[0], cap_taps);
          chk("stall_idx_held", idx_o[0], 2);
          chk("stall_in_ready", ready_o[0], 1'b0);
        end
      end
      #1;
      if (idx_o[0] == 2 && stalls < 3) begin
        sready_i[0] = 1'b0;
        valid_i[0]  = 1'b1;
        data_i[0]   = 8'h77;
        stalls++;
      end else begin
        sready_i[0] = 1'b1;
        valid_i[0]  = 1'b0;
        hs++;
      end
    end
    sready_i[0] = 1'b1;
    valid_i[0]  = 1'b0;
    chk("stall_handshakes", hs, 8);
    chk("stall_cycles", stalls, 3);

    // Block mode: eight samples, two bursts.
    for (int s = 0; s < 8; s++) begin
      send(1, W'(10 + s));
      @(negedge clk);
      chk("block_fill", fill_o[1], (s % 4) + 1);
      chk("block_burst", sv_o[1], (s % 4) == 3);
      if ((s % 4) == 3) begin
        wait_done(1);
        chk("block_fill_cleared", fill_o[1], 0);
      end
    end
    chk("block_burst_count", bursts1, 2);

    // Reset mid-burst.
    send(0, 8'h21);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sv_o[0] && idx_o[0] == 3) break;
    end
    chk("abort_at_idx3", idx_o[0], 3);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", sv_o[0], 1'b0);
    chk("abort_taps", taps_o[0], '0);
    chk("abort_fill", fill_o[0], '0);
    chk("abort_ready", ready_o[0], 1'b1);

    // Clear together with an offered sample.
    send(0, 8'h33);
    @(negedge clk);
    chk("pre_clr_fill", fill_o[0], 1);
    #1;
    clr_i[0]   = 1'b1;
    valid_i[0] = 1'b1;
    data_i[0]  = 8'h44;
    #1 chk("clr_in_ready", ready_o[0], 1'b1);
    @(posedge clk);
    #1;
    clr_i[0]   = 1'b0;
    valid_i[0] = 1'b0;
    @(negedge clk);
    chk("clr_fill", fill_o[0], '0);
    chk("clr_taps", taps_o[0], '0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
